// File: rtl/sx1255_axil_regs.sv
// AXI4-Lite register file for the SX1255 top: NUM_REGS 32-bit control registers with per-register write pulses.
// Optional build macro SX1255_AXIL_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module sx1255_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_REGS           = 4
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
   output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int NB    = DW / 8;
   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SX1255_AXIL_SLVERR_EN
   localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   typedef struct packed {
      w_state_t w_state;
      r_state_t r_state;
      logic     aw_latched;
      logic     w_latched;
   } fsm_dbg_t;

   // Handshakes: a transfer happens on a rising ACLK edge where VALID and READY are both high;
   // a source holds VALID and its payload stable until that edge, READY never waits on VALID.
   w_state_t         w_state_q, w_state_d;
   r_state_t         r_state_q, r_state_d;
   logic             aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
   logic [IDX_W-1:0] awidx_q, awidx_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [NB-1:0]    wstrb_q, wstrb_d;
   logic             bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             rvalid_q, rvalid_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [NUM_REGS-1:0] pulse_q, pulse_d;
   logic [DW-1:0]    regs_q [NUM_REGS];
   logic [DW-1:0]    regs_d [NUM_REGS];
   logic             aw_ready, w_ready, ar_ready, w_hit, r_hit;
   fsm_dbg_t         fsm_dbg;
   logic             unused_sink;

   always_comb begin
      w_state_d = w_state_q;
      aw_lat_d  = aw_lat_q;
      w_lat_d   = w_lat_q;
      awidx_d   = awidx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      regs_d    = regs_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      w_hit     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_ready = !aw_lat_q;
            w_ready  = !w_lat_q;
            if (S_AXI_AWVALID && aw_ready) begin
               aw_lat_d = 1'b1;
               awidx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && w_ready) begin
               w_lat_d = 1'b1;
               wdata_d = S_AXI_WDATA;
               wstrb_d = S_AXI_WSTRB;
            end
            // Commit uses the merged view: latched halves plus anything handshaking this cycle.
            if (aw_lat_d && w_lat_d) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (awidx_d == IDX_W'(i)) begin
                     w_hit      = 1'b1;
                     pulse_d[i] = 1'b1;
                     for (int b = 0; b < NB; b++) begin
                        if (wstrb_d[b]) regs_d[i][8*b +: 8] = wdata_d[8*b +: 8];
                     end
                  end
               end
               bresp_d   = w_hit ? RESP_OKAY : RESP_UNMAPPED;
               bvalid_d  = 1'b1;
               aw_lat_d  = 1'b0;
               w_lat_d   = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Reads sample regs_q, so a same-cycle write commit is seen only by later reads.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_ready  = 1'b0;
      r_hit     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (S_AXI_ARVALID) begin
               rdata_d = '0;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] == IDX_W'(i)) begin
                     r_hit   = 1'b1;
                     rdata_d = regs_q[i];
                  end
               end
               rresp_d   = r_hit ? RESP_OKAY : RESP_UNMAPPED;
               rvalid_d  = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_lat_q  <= 1'b0;
         w_lat_q   <= 1'b0;
         awidx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         pulse_q   <= '0;
         regs_q    <= '{default: '0};
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_lat_q  <= aw_lat_d;
         w_lat_q   <= w_lat_d;
         awidx_q   <= awidx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         pulse_q   <= pulse_d;
         regs_q    <= regs_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[DW*g +: DW] = regs_q[g];
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign reg_wr_pulse  = pulse_q;

   assign fsm_dbg     = '{w_state: w_state_q, r_state: r_state_q,
                          aw_latched: aw_lat_q, w_latched: w_lat_q};
   assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                          S_AXI_ARADDR[1:0], fsm_dbg};

endmodule

// File: tb/tb_sx1255_axil_regs.sv
// Self-checking bench for sx1255_axil_regs: directed AXI4-Lite sequences plus random traffic,
// scored against an array model of the register file through expected-response queues.
module tb_sx1255_axil_regs;

  localparam int NR = 4;
`ifdef SX1255_AXIL_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0] reg_wr_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NR];
  logic [1:0]    exp_b_q[$];
  logic [33:0]   exp_r_q[$];
  logic [NR-1:0] exp_p_q[$];
  logic bvalid_prev = 1'b0;

  sx1255_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(NR)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [32*NR-1:0] model_flat();
    logic [32*NR-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && !bvalid_prev) begin
        if (exp_p_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_pulse actual=unexpected_b required=none");
        end else check("wr_pulse", reg_wr_pulse, exp_p_q.pop_front());
      end else check("wr_pulse_idle", reg_wr_pulse, '0);
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bresp actual=unexpected required=none");
        end else check("bresp", bresp, exp_b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdata actual=unexpected required=none");
        end else check("rresp_rdata", {rresp, rdata}, exp_r_q.pop_front());
      end
    end
    bvalid_prev = bvalid;
  end

  // driver: AW starts aw_dly cycles in, W starts w_dly cycles in; b_hold<0 leaves B pending
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    int idx;
    bit mapped, aw_done, w_done, aw_rdy, w_rdy;
    int c;
    logic [1:0] er;
    idx = int'(addr >> 2);
    mapped = idx < NR;
    er = mapped ? 2'b00 : UNMAP_RESP;
    exp_b_q.push_back(er);
    exp_p_q.push_back(mapped ? NR'(1 << idx) : '0);
    bready = (b_hold == 0);
    aw_done = 0; w_done = 0; c = 0;
    @(posedge clk); #1;
    while (!(aw_done && w_done) && c < 50) begin
      if (!aw_done && c >= aw_dly) begin awvalid = 1; awaddr = addr; end
      if (!w_done && c >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
      @(negedge clk);
      if (w_done) check("wready_low_after_w", wready, 0);
      if (aw_done) check("awready_low_after_aw", awready, 0);
      aw_rdy = awready; w_rdy = wready;
      @(posedge clk);
      if (awvalid && aw_rdy) aw_done = 1;
      if (wvalid && w_rdy) w_done = 1;
      #1;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      c++;
    end
    if (!(aw_done && w_done)) begin
      checks++; failures++;
      $display("FAIL aw_w_handshake actual=timeout required=accept");
      awvalid = 0; wvalid = 0;
      return;
    end
    if (mapped)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    @(negedge clk);
    check("b_latency", bvalid, 1);
    if (b_hold < 0) return;
    for (int k = 0; k < b_hold; k++) begin
      check("b_hold_valid", bvalid, 1);
      check("b_hold_resp", bresp, er);
      check("b_hold_awready", awready, 0);
      check("b_hold_wready", wready, 0);
      @(negedge clk);
    end
    if (b_hold > 0) begin @(posedge clk); #1; bready = 1; end
    c = 0;
    do begin @(posedge clk); #1; c++; end while (bvalid && c < 20);
    check("b_complete", bvalid, 0);
    check("reg_out", reg_out, model_flat());
    bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_hold);
    int idx, c;
    bit mapped;
    logic [33:0] e;
    idx = int'(addr >> 2);
    mapped = idx < NR;
    e = mapped ? {2'b00, model[idx]} : {UNMAP_RESP, 32'h0};
    exp_r_q.push_back(e);
    rready = (r_hold == 0);
    @(posedge clk); #1;
    arvalid = 1; araddr = addr;
    c = 0;
    @(negedge clk);
    while (!arready && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    check("r_latency", rvalid, 1);
    for (int k = 0; k < r_hold; k++) begin
      check("r_hold_valid", rvalid, 1);
      check("r_hold_data", {rresp, rdata}, e);
      check("r_hold_arready", arready, 0);
      @(negedge clk);
    end
    if (r_hold > 0) begin @(posedge clk); #1; rready = 1; end
    c = 0;
    do begin @(posedge clk); #1; c++; end while (rvalid && c < 20);
    check("r_complete", rvalid, 0);
    rready = 0;
  endtask

  initial begin
    logic [31:0] vals [4];
    int c;
    vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001; vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_reg_out", reg_out, 0);

    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), vals[i], 4'hF, 0, 0, 0);
      axi_read(5'(4 * i), 0);
    end
    axi_write(5'h08, 32'h55667788, 4'hF, 3, 0, 0);
    axi_write(5'h0C, 32'h99aabbcc, 4'hF, 0, 2, 0);
    axi_read(5'h08, 0);
    axi_read(5'h0C, 0);
    axi_write(5'h04, 32'h11223344, 4'b0101, 0, 0, 0);
    axi_read(5'h04, 0);
    check("strobe_merge", model[1], 32'hab220044);
    axi_write(5'h00, 32'hffffffff, 4'b0000, 1, 0, 0);
    axi_write(5'h08, 32'hcafef00d, 4'hF, 0, 0, 5);
    axi_read(5'h08, 5);
    axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(5'h10, 0);
    axi_read(5'h1F, 1);
    axi_read(5'h07, 0);
    fork
      axi_write(5'h0C, 32'h0badbeef, 4'hF, 0, 0, 0);
      axi_read(5'h0C, 0);
    join
    axi_read(5'h0C, 0);

    for (int n = 0; n < 40; n++) begin
      axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    axi_write(5'h00, 32'h13572468, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'hfeedface, 4'hF, 0, 0, -1);
    #2 rst = 1;
    #1;
    check("arst_bvalid", bvalid, 0);
    check("arst_reg_out", reg_out, 0);
    exp_b_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);
    axi_write(5'h08, 32'h24681357, 4'hF, 0, 0, 0);
    axi_read(5'h08, 0);
    axi_read(5'h00, 0);

    c = 0;
    while ((exp_b_q.size() + exp_r_q.size() + exp_p_q.size()) != 0 && c < 50) begin
      @(negedge clk); c++;
    end
    check("queues_drained", exp_b_q.size() + exp_r_q.size() + exp_p_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sx1255_axil_regs.md
Name: sx1255_axil_regs

Overview:
AXI4-Lite slave (responder) register file for the SX1255 top. It terminates the S00_AXI port driven by the AXI4-Lite master BFM. It holds NUM_REGS 32-bit control registers, which it exposes to the SX1255 datapath as a flat bus, and it emits one write-strobe pulse per register. Write and read channels run independent FSMs; every transaction returns a response.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width; register index = addr[ADDR_WIDTH-1:2]
NUM_REGS, 4, number of implemented registers (1..2^(ADDR_WIDTH-2))

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  32*NUM_REGS  register contents; reg i at bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on each commit to reg i

Behaviour:
- Reset (async assert, sync release at the ACLK edge):
  - All registers, RDATA and BRESP/RRESP are 0.
  - BVALID, RVALID and reg_wr_pulse are 0.
  - AWREADY, WREADY and ARREADY are 1.
  - Latched flags are cleared.
- Reset asserted mid-transaction aborts the transaction and discards it. No response is issued.

Write FSM (states W_IDLE, W_RESP):
- W_IDLE:
  - AWREADY = !aw_latched; WREADY = !w_latched.
  - AW and W may arrive in the same cycle or in either order. Each is latched on its handshake.
  - The cycle after both are latched (or both handshake together), the FSM commits:
    - Each byte b with WSTRB[b]=1 is written to the addressed register.
    - reg_wr_pulse[idx] goes high for one cycle.
    - BVALID=1 and BRESP=OKAY; the FSM goes to W_RESP and clears the latches.
- W_RESP:
  - AWREADY=WREADY=0.
  - BVALID and BRESP are held stable until BREADY. Then BVALID=0 and the FSM returns to W_IDLE.
- Latency: AW+W handshake in cycle N -> register updated and BVALID at N+1.
  - Earliest next AW/W acceptance is the cycle after the B handshake.
- WSTRB=0: no bytes change, but the pulse still fires and OKAY is returned.

Read FSM (states R_IDLE, R_DATA):
- R_IDLE:
  - ARREADY=1. On handshake at cycle N, RDATA is loaded from the addressed register and RVALID=1 at N+1.
  - The FSM goes to R_DATA and ARREADY=0.
- R_DATA: RDATA, RRESP and RVALID are held until RREADY, then the FSM returns to R_IDLE.
- Simultaneous write commit and AR handshake to the same register in one cycle: RDATA returns the pre-write value.

Decode:
- addr[1:0] is ignored (unaligned addresses are treated as aligned).
- An index >= NUM_REGS is unmapped.
- Unmapped write: no register changes and no pulse fires. Response is per the optional feature.
- Unmapped read: RDATA=0. Response is per the optional feature.

Optional Feature:
- Macro: SX1255_AXIL_SLVERR_EN.
- Defined: unmapped accesses return BRESP/RRESP=2'b10 (SLVERR).
- Undefined: all accesses return OKAY (2'b00). Unmapped writes are silently dropped; unmapped reads return 0.

Test Plan:
1. Write 0x0101FFFF, 0xabcd0001, 0xdead0011 and 0xbeef0011 to 0x0, 0x4, 0x8 and 0xC (AW+W same cycle, BREADY=1), reading each back -> BRESP=RRESP=0 and read data matches. reg_wr_pulse[i] fires once per write; BVALID appears exactly 1 cycle after the handshake.
2. Write: W presented 3 cycles before AW, then AW 2 cycles before W -> both commit correctly. WREADY is low after the W latch until the B handshake.
3. Reg1 = 0xabcd0001, then write 0x11223344 with WSTRB=4'b0101 -> readback 0xab220044.
4. Hold BREADY=0 for 5 cycles after a write, and RREADY=0 for 5 cycles after a read -> BVALID/BRESP and RVALID/RDATA stay stable. AWREADY, WREADY and ARREADY stay low throughout.
5. Write to 0x10 then read 0x10 (NUM_REGS=4) -> regs unchanged and RDATA=0. Response is 2'b10 with SX1255_AXIL_SLVERR_EN, 2'b00 without.
6. Assert ARESET while BVALID=1 with regs nonzero -> all regs 0 and BVALID=0 immediately. Ready signals are 1 after release, and a new write succeeds.
